// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline.
// Handles load-use, EX redirects and variable-latency dmem freezes.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_pcsel,
    input  logic                  mem_access,
    input  logic                  dmem_ready,
    output logic                  dmem_req,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_write,
    output logic                  idex_flush,
    output logic                  exmem_hold,
    output logic                  memwb_bubble,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t state;
    state_t state_nxt;

    logic pending;
    logic freeze;
    logic load_use;
    logic sel_rst;
    logic sel_frz;
    logic sel_redir;
    logic sel_lu;
    logic stall_inc;
    logic flush_inc;

    assign pending  = (state == S_RUN && mem_access) || state == S_WAIT;
    assign freeze   = pending && !dmem_ready;
    assign load_use = ex_memread && (ex_rd != '0)
                   && (ex_rd == id_rs1 || ex_rd == id_rs2);

    // Mutually exclusive selects so the decoder below stays one-hot.
    assign sel_rst   = reset;
    assign sel_frz   = !reset && freeze;
    assign sel_redir = !reset && !freeze && ex_pcsel;
    assign sel_lu    = !reset && !freeze && !ex_pcsel && load_use;

    assign stall_inc = !reset && (freeze || (load_use && !ex_pcsel));
    assign flush_inc = !reset && ex_pcsel && !freeze;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:  if (mem_access && !dmem_ready) state_nxt = S_WAIT;
            S_WAIT: if (dmem_ready) state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        dmem_req     = pending;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_flush   = 1'b0;
        exmem_hold   = 1'b0;
        memwb_bubble = 1'b0;
        unique case (1'b1)
            sel_rst: begin
                dmem_req     = 1'b0;
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                ifid_flush   = 1'b1;
                idex_write   = 1'b0;
                idex_flush   = 1'b1;
                memwb_bubble = 1'b1;
            end
            sel_frz: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_hold   = 1'b1;
                memwb_bubble = 1'b1;
            end
            sel_redir: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            sel_lu: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_inc && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
            if (flush_inc && flush_count != '1) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule
